// File: rtl/conv_buf_pkg.sv
// Shared constants and types for the stride-2 convolution line buffer.
// The write and read controllers both import this package.
package conv_buf_pkg;

    localparam int IMG_W        = 9;
    localparam int BUF_ROWS     = 16;
    localparam int BUF_DEPTH    = IMG_W * BUF_ROWS;
    localparam int RELEASE_ROWS = 2;
    localparam int VALID_ROWS   = 3;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 16;
    localparam int COL_W        = 4;
    localparam int ROWS_W       = 5;

    typedef logic [ADDR_W-1:0] buf_addr_t;
    typedef logic [DATA_W-1:0] pix_t;
    typedef logic [COL_W-1:0]  col_t;
    typedef logic [ROWS_W-1:0] row_cnt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PRIME = 2'd1,
        READY = 2'd2,
        FULL  = 2'd3
    } wc_state_t;

    localparam buf_addr_t ADDR_ZERO  = buf_addr_t'(0);
    localparam buf_addr_t ADDR_LAST  = buf_addr_t'(BUF_DEPTH - 1);
    localparam col_t      COL_ZERO   = col_t'(0);
    localparam col_t      COL_LAST   = col_t'(IMG_W - 1);
    localparam row_cnt_t  ROWS_NONE  = row_cnt_t'(0);
    localparam row_cnt_t  ROWS_VALID = row_cnt_t'(VALID_ROWS);
    localparam row_cnt_t  ROWS_FULL  = row_cnt_t'(BUF_ROWS);
    localparam row_cnt_t  ROWS_REL   = row_cnt_t'(RELEASE_ROWS);

    // Occupancy state is decided purely by the number of complete rows held.
    function automatic wc_state_t state_of(input row_cnt_t rows);
        wc_state_t s;
        if (rows == ROWS_NONE) begin
            s = EMPTY;
        end else if (rows < ROWS_VALID) begin
            s = PRIME;
        end else if (rows < ROWS_FULL) begin
            s = READY;
        end else begin
            s = FULL;
        end
        return s;
    endfunction

    function automatic buf_addr_t next_addr(input buf_addr_t a);
        buf_addr_t n;
        if (a == ADDR_LAST) begin
            n = ADDR_ZERO;
        end else begin
            n = a + buf_addr_t'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/write_controller_if.sv
// Pixel stream input and RAM write port of the line-buffer write controller.
// master = upstream source / RAM side, slave = write_controller.
interface write_controller_if;
    import conv_buf_pkg::*;

    logic      inValid;
    pix_t      inData;
    logic      inReady;
    logic      wEn;
    buf_addr_t wAddr;
    pix_t      wData;

    modport master (
        output inValid,
        output inData,
        input  inReady,
        input  wEn,
        input  wAddr,
        input  wData
    );

    modport slave (
        input  inValid,
        input  inData,
        output inReady,
        output wEn,
        output wAddr,
        output wData
    );

endinterface

// File: rtl/write_controller_row_occupancy.sv
// Complete-row occupancy counter, occupancy FSM and sticky release-error flag.
// Releases are judged against the count before this cycle's update.
module row_occupancy
    import conv_buf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      row_done,
    input  logic      rel_pulse,
    output row_cnt_t  rows_stored,
    output wc_state_t state,
    output logic      valid_to_read,
    output logic      rel_err
);

    row_cnt_t  rows_r;
    wc_state_t state_r;
    logic      vtr_r;
    logic      err_r;

    logic      rel_valid_s;
    logic      rel_bad_s;
    row_cnt_t  rows_next_s;
    wc_state_t state_next_s;

    // Next occupancy: +1 on a completed row, -2 on an accepted release.
    always_comb begin
        rel_valid_s  = rel_pulse && (rows_r >= ROWS_VALID);
        rel_bad_s    = rel_pulse && !rel_valid_s;
        rows_next_s  = rows_r + {4'd0, row_done};
        if (rel_valid_s) begin
            rows_next_s = rows_next_s - ROWS_REL;
        end else begin
            rows_next_s = rows_next_s;
        end
        state_next_s = state_of(rows_next_s);
    end

    // Occupancy FSM with registered count, state and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_r  <= ROWS_NONE;
            state_r <= EMPTY;
            vtr_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            rows_r  <= rows_next_s;
            state_r <= state_next_s;
            case (state_next_s)
                READY:   vtr_r <= 1'b1;
                FULL:    vtr_r <= 1'b1;
                EMPTY:   vtr_r <= 1'b0;
                PRIME:   vtr_r <= 1'b0;
                default: vtr_r <= 1'b0;
            endcase
            if (rel_bad_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign rows_stored   = rows_r;
    assign state         = state_r;
    assign valid_to_read = vtr_r;
    assign rel_err       = err_r;

endmodule

// File: rtl/write_controller.sv
// Line-buffer write controller: raster pixels into a 16x9 row ring, with occupancy tracking.
// Optional stall counter output enabled by defining WRITE_CTRL_STALL_CNT_EN.
module write_controller
    import conv_buf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    write_controller_if.slave  bus,
    input  logic               rowRelease,
    output logic               validToRead,
    output logic [ROWS_W-1:0]  rowsStored,
    output logic               relErr
`ifdef WRITE_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]        stallCount
`endif
);

    logic      running_r;
    col_t      col_r;
    buf_addr_t wptr_r;
    logic      wen_r;
    buf_addr_t waddr_r;
    pix_t      wdata_r;

    logic      in_ready_s;
    logic      fire_s;
    logic      row_done_s;
    wc_state_t state_s;
    row_cnt_t  rows_s;

    // Ready is held low for the reset cycle, then follows occupancy.
    assign in_ready_s = running_r && (state_s != FULL);
    assign fire_s     = bus.inValid && in_ready_s;
    assign row_done_s = fire_s && (col_r == COL_LAST);

    // Column counter, write pointer and registered RAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_r <= 1'b0;
            col_r     <= COL_ZERO;
            wptr_r    <= ADDR_ZERO;
            wen_r     <= 1'b0;
            waddr_r   <= ADDR_ZERO;
            wdata_r   <= {DATA_W{1'b0}};
        end else begin
            running_r <= 1'b1;
            if (fire_s) begin
                wen_r   <= 1'b1;
                waddr_r <= wptr_r;
                wdata_r <= bus.inData;
                wptr_r  <= next_addr(wptr_r);
                if (row_done_s) begin
                    col_r <= COL_ZERO;
                end else begin
                    col_r <= col_r + col_t'(1);
                end
            end else begin
                wen_r   <= 1'b0;
                waddr_r <= waddr_r;
                wdata_r <= wdata_r;
                wptr_r  <= wptr_r;
                col_r   <= col_r;
            end
        end
    end

    row_occupancy u_row_occupancy (
        .clk           (clk),
        .reset         (reset),
        .row_done      (row_done_s),
        .rel_pulse     (rowRelease),
        .rows_stored   (rows_s),
        .state         (state_s),
        .valid_to_read (validToRead),
        .rel_err       (relErr)
    );

    assign rowsStored  = rows_s;
    assign bus.inReady = in_ready_s;
    assign bus.wEn     = wen_r;
    assign bus.wAddr   = waddr_r;
    assign bus.wData   = wdata_r;

`ifdef WRITE_CTRL_STALL_CNT_EN
    logic [15:0] stall_r;

    // Saturating count of cycles where upstream offers data that is refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r <= 16'h0000;
        end else if (bus.inValid && !in_ready_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stallCount = stall_r;
`endif

endmodule

// File: tb/tb_write_controller.sv
// Self-checking bench for write_controller: table-driven scenario steps plus a
// write scoreboard, with hand-written backpressure, wrap and async-reset sequences.
module tb_write_controller;
    import conv_buf_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rowRelease = 1'b0;
    logic        validToRead;
    logic        relErr;
    logic [4:0]  rowsStored;
`ifdef WRITE_CTRL_STALL_CNT_EN
    logic [15:0] stallCount;
`endif

    write_controller_if bus();

    write_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .rowRelease  (rowRelease),
        .validToRead (validToRead),
        .rowsStored  (rowsStored),
        .relErr      (relErr)
`ifdef WRITE_CTRL_STALL_CNT_EN
        ,
        .stallCount  (stallCount)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t sb[$];

    int mrows = 0;
    int mcol = 0;
    int maddr = 0;
    int next_data = 1;
    bit merr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && bus.wEn === 1'b1) begin
            if (sb.size() == 0) begin
                chk("write_expected", 32'(bus.wEn), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wAddr", 32'(bus.wAddr), 32'(e.addr));
                chk("wData", 32'(bus.wData), 32'(e.data));
            end
        end
    end

    task automatic model_step(input bit acc, input bit rel);
        bit rd;
        bit vrel;
        rd = acc && (mcol == IMG_W - 1);
        vrel = rel && (mrows >= 3);
        if (acc) begin
            sb.push_back('{addr: 10'(maddr), data: 16'(next_data)});
            maddr = (maddr == BUF_DEPTH - 1) ? 0 : maddr + 1;
            mcol = rd ? 0 : mcol + 1;
            next_data++;
        end
        if (rel && !vrel) merr = 1'b1;
        mrows = mrows + (rd ? 1 : 0) - (vrel ? 2 : 0);
    endtask

    task automatic check_model();
        chk("rowsStored", 32'(rowsStored), 32'(mrows));
        chk("validToRead", 32'(validToRead), 32'(mrows >= 3));
        chk("relErr", 32'(relErr), 32'(merr));
        chk("inReady", 32'(bus.inReady), 32'(mrows != 16));
    endtask

    task automatic send_pix(input bit rel);
        int n;
        n = 0;
        bus.inValid = 1'b1;
        bus.inData = 16'(next_data);
        while (bus.inReady !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.inReady !== 1'b1) begin
            chk("ready_timeout", 32'(bus.inReady), 32'd1);
            bus.inValid = 1'b0;
            return;
        end
        rowRelease = rel;
        model_step(1'b1, rel);
        @(negedge clk);
        bus.inValid = 1'b0;
        rowRelease = 1'b0;
        check_model();
    endtask

    task automatic release_only();
        rowRelease = 1'b1;
        model_step(1'b0, 1'b1);
        @(negedge clk);
        rowRelease = 1'b0;
        check_model();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.inValid = 1'b0;
        rowRelease = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_wEn", 32'(bus.wEn), 32'd0);
        chk("rst_wAddr", 32'(bus.wAddr), 32'd0);
        chk("rst_wData", 32'(bus.wData), 32'd0);
        chk("rst_inReady", 32'(bus.inReady), 32'd0);
        chk("rst_rowsStored", 32'(rowsStored), 32'd0);
        chk("rst_validToRead", 32'(validToRead), 32'd0);
        chk("rst_relErr", 32'(relErr), 32'd0);
`ifdef WRITE_CTRL_STALL_CNT_EN
        chk("rst_stallCount", 32'(stallCount), 32'd0);
`endif
        sb.delete();
        mrows = 0;
        mcol = 0;
        maddr = 0;
        merr = 1'b0;
        next_data = 1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_inReady", 32'(bus.inReady), 32'd1);
    endtask

    typedef struct {
        bit do_reset;
        int npix;
        bit rel_last;
        bit rel_after;
        int exp_rows;
        bit exp_vtr;
        bit exp_rdy;
        bit exp_err;
    } step_t;

    step_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.inValid = 1'b0;
        bus.inData = 16'h0000;

        // {reset, pixels, release with last pixel, release after, rows, vtr, ready, relErr}
        tbl[0] = '{1'b1,   9, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0,   0, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0,   9, 1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1,  26, 1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0,   1, 1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0,   8, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0,   1, 1'b1, 1'b0,  2, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0,   9, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1,  27, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 117, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0};

        for (int s = 0; s < 10; s++) begin
            if (tbl[s].do_reset) apply_reset();
            for (int p = 0; p < tbl[s].npix; p++) begin
                send_pix(tbl[s].rel_last && (p == tbl[s].npix - 1));
            end
            if (tbl[s].rel_after) release_only();
            chk($sformatf("step%0d_rows", s), 32'(rowsStored), 32'(tbl[s].exp_rows));
            chk($sformatf("step%0d_vtr", s), 32'(validToRead), 32'(tbl[s].exp_vtr));
            chk($sformatf("step%0d_ready", s), 32'(bus.inReady), 32'(tbl[s].exp_rdy));
            chk($sformatf("step%0d_relErr", s), 32'(relErr), 32'(tbl[s].exp_err));
        end

        // Buffer full: pixel 145 held valid must not be written.
        bus.inValid = 1'b1;
        bus.inData = 16'(next_data);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_inReady", 32'(bus.inReady), 32'd0);
            chk("bp_wEn", 32'(bus.wEn), 32'd0);
        end
        rowRelease = 1'b1;
        model_step(1'b0, 1'b1);
        @(negedge clk);
        rowRelease = 1'b0;
        chk("bp_rel_rows", 32'(rowsStored), 32'd14);
        chk("bp_rel_ready", 32'(bus.inReady), 32'd1);
        send_pix(1'b0);
        chk("wrap_wEn", 32'(bus.wEn), 32'd1);
        chk("wrap_wAddr", 32'(bus.wAddr), 32'd0);
        chk("wrap_wData", 32'(bus.wData), 32'd145);

        // Asynchronous reset mid-row discards the partial row.
        apply_reset();
        for (int p = 0; p < 13; p++) send_pix(1'b0);
        chk("mid_rows", 32'(rowsStored), 32'd1);
        apply_reset();
        send_pix(1'b0);
        chk("after_rst_wAddr", 32'(bus.wAddr), 32'd0);
        chk("after_rst_wData", 32'(bus.wData), 32'd1);
        chk("after_rst_rows", 32'(rowsStored), 32'd0);

`ifdef WRITE_CTRL_STALL_CNT_EN
        apply_reset();
        for (int p = 0; p < 144; p++) send_pix(1'b0);
        bus.inValid = 1'b1;
        bus.inData = 16'(next_data);
        repeat (10) @(negedge clk);
        chk("stall_10", 32'(stallCount), 32'd10);
        repeat (65524) @(negedge clk);
        chk("stall_fffe", 32'(stallCount), 32'hFFFE);
        @(negedge clk);
        chk("stall_ffff", 32'(stallCount), 32'hFFFF);
        @(negedge clk);
        chk("stall_sat", 32'(stallCount), 32'hFFFF);
        bus.inValid = 1'b0;
`endif

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
